// File: rtl/am2906.sv
// am2906: bus transceiver with a clocked driver register, a transparent
// receiver latch and an optional parity generator/checker.
// Optional feature macro: AM2906_PARITY_EN (parity on 'odd'; odd = 0 when undefined).
module am2906 #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             drcp,
   input  logic             rst_,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sel,
   input  logic             be_,
   inout  wire  [WIDTH-1:0] bus_,
   input  logic             rle_,
   output logic [WIDTH-1:0] r,
   output logic             odd
);

   logic [WIDTH-1:0] mux;
   logic [WIDTH-1:0] dreg;
   logic [WIDTH-1:0] rlatch;
   logic [WIDTH-1:0] rx;

   // Driver input select
   assign mux = sel ? b : a;

   // Driver register, async clear
   always_ff @(posedge drcp or negedge rst_) begin
      if (!rst_) dreg <= '0;
      else       dreg <= mux;
   end

   // Inverted bus drive; released to high-impedance when receiving
   assign bus_ = be_ ? {WIDTH{1'bz}} : ~dreg;

   // Receiver source: our own driven data while driving, the external bus otherwise
   assign rx = be_ ? ~bus_ : dreg;

   // Receiver latch: transparent while rle_ low, async clear
   always_latch begin
      if (!rst_)      rlatch <= '0;
      else if (!rle_) rlatch <= rx;
   end

   assign r = rlatch;

`ifdef AM2906_PARITY_EN
   // Parity over outgoing mux data when driving, over latched data when receiving
   always_comb begin
      odd = 1'bx;
      case (be_)
         1'b0:    odd = ^mux;
         1'b1:    odd = ^rlatch;
         default: odd = 1'bx;
      endcase
   end
`else
   assign odd = 1'b0;
`endif

endmodule

// File: tb/tb_am2906.sv
// tb_am2906: table-driven directed vectors plus randomized steps against a
// behavioural model of the transceiver.
module tb_am2906;

   localparam int unsigned W = 4;
`ifdef AM2906_PARITY_EN
   localparam bit PAR_ON = 1'b1;
`else
   localparam bit PAR_ON = 1'b0;
`endif

   logic         drcp;
   logic         rst_;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         sel;
   logic         be_;
   logic         rle_;
   logic [W-1:0] r;
   logic         odd;
   wire  [W-1:0] bus_;
   logic         ext_en;
   logic [W-1:0] ext_val;

   assign bus_ = ext_en ? ext_val : {W{1'bz}};

   am2906 #(.WIDTH(W)) dut (
      .drcp (drcp),
      .rst_ (rst_),
      .a    (a),
      .b    (b),
      .sel  (sel),
      .be_  (be_),
      .bus_ (bus_),
      .rle_ (rle_),
      .r    (r),
      .odd  (odd)
   );

   typedef struct {
      logic         rst;
      logic         sel;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         be;
      logic         rle;
      logic [W-1:0] ext;
      logic         clk;
      logic [W-1:0] exp_r;
      logic         exp_odd;
      logic         chk_bus;
      logic [W-1:0] exp_bus;
   } vec_t;

   int total;
   int passed;
   int fails;

   function automatic vec_t mk(input logic rst, input logic s, input logic [W-1:0] va,
                               input logic [W-1:0] vb, input logic be, input logic rle,
                               input logic [W-1:0] ext, input logic clk,
                               input logic [W-1:0] er, input logic eo,
                               input logic cb, input logic [W-1:0] eb);
      vec_t v;
      v.rst = rst; v.sel = s; v.a = va; v.b = vb; v.be = be; v.rle = rle;
      v.ext = ext; v.clk = clk; v.exp_r = er; v.exp_odd = eo;
      v.chk_bus = cb; v.exp_bus = eb;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s step %0d: got %b, expected %b", name, idx, act, exp);
      end else begin
         passed++;
      end
   endtask

   // Hold is asserted before data moves and transparency is opened after it settles,
   // so a latch closing and its data changing never coincide.
   task automatic apply(input vec_t v);
      if (v.rle) begin
         rle_ = 1'b1;
         #1;
      end
      rst_ = v.rst; sel = v.sel; a = v.a; b = v.b;
      ext_en = v.be; ext_val = v.ext; be_ = v.be;
      #1;
      if (v.clk) begin
         drcp = 1'b1;
         #2;
         drcp = 1'b0;
         #1;
      end
      if (!v.rle) begin
         rle_ = 1'b0;
         #1;
      end
      #1;
   endtask

   task automatic compare(input vec_t v, input int idx);
      chk("r", idx, r, v.exp_r);
      chk("odd", idx, {3'b000, odd}, {3'b000, PAR_ON ? v.exp_odd : 1'b0});
      if (v.chk_bus) chk("bus_", idx, bus_, v.exp_bus);
   endtask

   vec_t tbl[$];

   // Model state
   logic [W-1:0] m_dreg;
   logic [W-1:0] m_rl;

   initial begin
      vec_t v;
      logic [W-1:0] m_mux;
      logic [W-1:0] m_bus;
      logic         m_odd;
      total = 0; passed = 0; fails = 0;
      drcp = 1'b0; rst_ = 1'b0; rle_ = 1'b0; be_ = 1'b1;
      sel = 1'b0; a = '0; b = '0; ext_en = 1'b1; ext_val = '0;
      #2;

      //          rst sel a        b        be rle ext      clk exp_r    odd chkbus bus
      tbl.push_back(mk(0, 0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000));
      tbl.push_back(mk(0, 0, 4'b1111, 4'b0000, 0, 0, 4'b0000, 1, 4'b0000, 0, 1, 4'b1111));
      tbl.push_back(mk(1, 0, 4'b0000, 4'b0000, 1, 0, 4'b1100, 0, 4'b0011, 0, 0, 4'b0000));
      tbl.push_back(mk(1, 0, 4'b0000, 4'b0000, 1, 0, 4'b0111, 0, 4'b1000, 1, 0, 4'b0000));
      tbl.push_back(mk(1, 0, 4'b0000, 4'b0000, 1, 1, 4'b0000, 0, 4'b1000, 1, 0, 4'b0000));
      tbl.push_back(mk(1, 0, 4'b0000, 4'b0000, 1, 1, 4'b1010, 0, 4'b1000, 1, 0, 4'b0000));
      tbl.push_back(mk(1, 0, 4'b0000, 4'b0000, 1, 1, 4'b1010, 1, 4'b1000, 1, 0, 4'b0000));
      tbl.push_back(mk(1, 0, 4'b1111, 4'b0000, 1, 1, 4'b1010, 1, 4'b1000, 1, 0, 4'b0000));
      tbl.push_back(mk(1, 1, 4'b1111, 4'b0101, 1, 1, 4'b1010, 1, 4'b1000, 1, 0, 4'b0000));
      tbl.push_back(mk(1, 1, 4'b1111, 4'b1010, 1, 1, 4'b1010, 1, 4'b1000, 1, 0, 4'b0000));
      tbl.push_back(mk(1, 1, 4'b1111, 4'b1010, 0, 1, 4'b0000, 0, 4'b1000, 0, 1, 4'b0101));
      tbl.push_back(mk(1, 0, 4'b1110, 4'b1010, 0, 1, 4'b0000, 0, 4'b1000, 1, 1, 4'b0101));
      tbl.push_back(mk(1, 1, 4'b1110, 4'b0110, 0, 1, 4'b0000, 0, 4'b1000, 0, 1, 4'b0101));
      tbl.push_back(mk(1, 1, 4'b1110, 4'b0110, 0, 0, 4'b0000, 0, 4'b1010, 0, 1, 4'b0101));
      tbl.push_back(mk(0, 1, 4'b1110, 4'b0110, 0, 0, 4'b0000, 0, 4'b0000, 0, 1, 4'b1111));
      tbl.push_back(mk(1, 1, 4'b1110, 4'b0110, 1, 0, 4'b0111, 0, 4'b1000, 1, 0, 4'b0000));
      tbl.push_back(mk(1, 0, 4'b0011, 4'b0110, 0, 0, 4'b0000, 1, 4'b0011, 0, 1, 4'b1100));

      foreach (tbl[i]) begin
         apply(tbl[i]);
         compare(tbl[i], i);
      end

      // Randomized steps; the first one is a reset so the model starts in step
      m_dreg = '0;
      m_rl   = '0;
      for (int n = 0; n < 300; n++) begin
         v.rst = (n == 0) ? 1'b0 : (($urandom % 16) != 0);
         v.sel = 1'($urandom);
         v.a   = W'($urandom);
         v.b   = W'($urandom);
         v.be  = 1'($urandom);
         v.rle = 1'($urandom);
         v.ext = W'($urandom);
         v.clk = 1'($urandom);

         m_mux = v.sel ? v.b : v.a;
         if (!v.rst)     m_dreg = '0;
         else if (v.clk) m_dreg = m_mux;
         m_bus = v.be ? v.ext : ~m_dreg;
         if (!v.rst)      m_rl = '0;
         else if (!v.rle) m_rl = ~m_bus;
         m_odd = v.be ? ($countones(m_rl) % 2 == 1) : ($countones(m_mux) % 2 == 1);

         v.exp_r   = m_rl;
         v.exp_odd = m_odd;
         v.chk_bus = !v.be;
         v.exp_bus = m_bus;

         apply(v);
         compare(v, 1000 + n);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
